// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and constants for the NTT control path
// Purpose: state encoding for the stage sequencer plus datapath-wide widths.
// Ports: none (package).
package ntt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    NEXT,
    DONE
  } seq_state_t;

  localparam int COEFF_W = 30;
  localparam int LOG_M_W = 4;
  localparam logic [LOG_M_W-1:0] OUT_PASS_LOG_T = 4'hF;

endpackage

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - fixed-depth register chain
// Purpose: delays a WIDTH-bit word by exactly DEPTH clock cycles.
// Ports:
//   clk   in  1      rising-edge clock
//   rst_n in  1      asynchronous active-low reset, clears every stage
//   din   in  WIDTH  word entering the chain
//   dout  out WIDTH  din from DEPTH cycles ago
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// rtl/ntt_stage_sequencer.sv - butterfly stage sequencer for the NTT router
// Purpose: walks log_m = 0..LOG_N-1 compute stages and one output pass,
//   issuing CYC read addresses per stage and draining the pipeline between
//   stages so no stage reads a word before the previous stage wrote it.
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   start                pulse, accepted only in IDLE
//   busy, done           transform in progress / one-cycle completion pulse
//   log_m, log_t         stage parameters to the router (log_t = 4'hF in output pass)
//   address_0, rd_en     read address and its valid
//   address_1, wr_en     writeback address (read address PIPE_LAT cycles later) and valid
//   bank_sel             ping-pong bank read this stage
//   out_valid            router output valid during the output pass
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 11,
  parameter int LOG_CYCLES     = 4,
  parameter int PIPE_LAT       = 4,
  parameter int ADDR_W         = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LOG_M_W-1:0] log_m,
  output logic [LOG_M_W-1:0] log_t,
  output logic [ADDR_W-1:0]  address_0,
  output logic [ADDR_W-1:0]  address_1,
  output logic               rd_en,
  output logic               wr_en,
  output logic               bank_sel,
  output logic               out_valid
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
  localparam logic [LOG_CYCLES-1:0] CNT_LAST   = LOG_CYCLES'((1 << LOG_CYCLES) - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
  localparam logic [LOG_M_W-1:0]    LOG_M_OUT  = LOG_M_W'(LOG_N);

  // Cores times read cycles must cover fewer words than the transform and the
  // read counter must fit in the address bus.
  if (ADDR_W < LOG_CYCLES || LOG_CORE_COUNT + LOG_CYCLES >= LOG_N) begin : g_bad_params
    $error("ntt_stage_sequencer: inconsistent address sizing parameters");
  end

  seq_state_t              state_q, state_d;
  logic [LOG_CYCLES-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [LOG_M_W-1:0]      log_m_d, log_t_d;
  logic                    bank_d;
  logic                    output_pass;
  logic                    rd_en_dly, pass_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      log_m    <= '0;
      log_t    <= '0;
      bank_sel <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      log_m    <= log_m_d;
      log_t    <= log_t_d;
      bank_sel <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    log_m_d = log_m;
    log_t_d = log_t;
    bank_d  = bank_sel;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          log_m_d = '0;
          log_t_d = LOG_M_W'(LOG_N - 1);
          bank_d  = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = NEXT;
      end
      NEXT: begin
        // The bank flips after every stage, the output pass included.
        bank_d = ~bank_sel;
        cnt_d  = '0;
        if (log_m == LOG_M_OUT) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          log_m_d = log_m + 1'b1;
          // LOG_N-1-(log_m+1); entering the output pass lands on all-ones.
          if (log_m + 1'b1 == LOG_M_OUT) log_t_d = OUT_PASS_LOG_T;
          else                           log_t_d = LOG_M_W'(LOG_N - 2) - log_m;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN) || (state_q == DRAIN) || (state_q == NEXT);
  assign done        = (state_q == DONE);
  assign rd_en       = (state_q == RUN);
  assign address_0   = rd_en ? ADDR_W'(cnt_q) : '0;
  assign output_pass = (log_m == LOG_M_OUT);

  ntt_delay_line #(
    .WIDTH(ADDR_W + 2),
    .DEPTH(PIPE_LAT)
  ) u_wb_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({address_0, rd_en, output_pass}),
    .dout ({address_1, rd_en_dly, pass_dly})
  );

  // During the output pass the delayed reads become router output, not writes.
  assign wr_en     = rd_en_dly & ~pass_dly;
  assign out_valid = rd_en_dly & pass_dly;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb/tb_ntt_stage_sequencer.sv - self-checking bench for ntt_stage_sequencer
module tb_ntt_stage_sequencer;

  localparam int LOG_N = 11;
  localparam int CYC   = 16;
  localparam int PIPE  = 4;
  localparam int STAGE = CYC + PIPE + 1;
  localparam int TOTAL = (LOG_N + 1) * STAGE;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       wr_en;
    logic       out_valid;
    logic       bank_sel;
    logic [3:0] log_m;
    logic [3:0] log_t;
    logic [8:0] a0;
    logic [8:0] a1;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, wr_en, bank_sel, out_valid;
  logic [3:0] log_m, log_t;
  logic [8:0] address_0, address_1;

  int checks = 0;
  int errors = 0;
  bit ran    = 1'b0;

  ntt_stage_sequencer #(
    .LOG_CORE_COUNT(5),
    .LOG_N         (LOG_N),
    .LOG_CYCLES    (4),
    .PIPE_LAT      (PIPE),
    .ADDR_W        (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .log_m    (log_m),
    .log_t    (log_t),
    .address_0(address_0),
    .address_1(address_1),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .bank_sel (bank_sel),
    .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle outputs: all zero after reset; after a completed transform the
  // stage registers hold the output-pass values and the bank is back at 0.
  function automatic exp_t ref_idle(input bit after_run);
    exp_t e;
    e = '0;
    if (after_run) begin
      e.log_m = 4'(LOG_N);
      e.log_t = 4'hF;
    end
    return e;
  endfunction

  // Expected outputs k cycles after start acceptance, from stage arithmetic.
  function automatic exp_t ref_active(input int k);
    exp_t e;
    int   s;
    int   p;
    e = ref_idle(1'b1);
    if (k >= TOTAL) begin
      e.done = (k == TOTAL);
      return e;
    end
    s = k / STAGE;
    p = k % STAGE;
    e.busy     = 1'b1;
    e.log_m    = 4'(s);
    e.log_t    = 4'(LOG_N - 1 - s);
    e.bank_sel = s[0];
    e.rd_en    = (p < CYC);
    e.a0       = (p < CYC) ? 9'(p) : 9'd0;
    if (p >= PIPE && p < CYC + PIPE) begin
      e.a1        = 9'(p - PIPE);
      e.wr_en     = (s < LOG_N);
      e.out_valid = (s == LOG_N);
    end
    return e;
  endfunction

  task automatic compare(input exp_t e, input string where);
    check({where, " busy"},      32'(busy),      32'(e.busy));
    check({where, " done"},      32'(done),      32'(e.done));
    check({where, " rd_en"},     32'(rd_en),     32'(e.rd_en));
    check({where, " wr_en"},     32'(wr_en),     32'(e.wr_en));
    check({where, " out_valid"}, 32'(out_valid), 32'(e.out_valid));
    check({where, " bank_sel"},  32'(bank_sel),  32'(e.bank_sel));
    check({where, " log_m"},     32'(log_m),     32'(e.log_m));
    check({where, " log_t"},     32'(log_t),     32'(e.log_t));
    check({where, " address_0"}, 32'(address_0), 32'(e.a0));
    check({where, " address_1"}, 32'(address_1), 32'(e.a1));
  endtask

  // Called at a falling edge with the DUT idle. Junk start pulses are thrown
  // in while busy (always at k=50); abort_k >= 0 pulls reset at that cycle.
  task automatic run_transform(input int abort_k, input bit start_at_done);
    int   dones   = 0;
    int   toggles = 0;
    logic prev_bank;
    compare(ref_idle(ran), "pre_start");
    prev_bank = bank_sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= TOTAL + 2; k++) begin
      compare(ref_active(k), $sformatf("k=%0d", k));
      if (done === 1'b1) dones++;
      if (bank_sel !== prev_bank) toggles++;
      prev_bank = bank_sel;
      if (k == abort_k) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 compare(ref_idle(1'b0), "async_reset");
        @(negedge clk);
        compare(ref_idle(1'b0), "reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        ran   = 1'b0;
        return;
      end
      start = 1'b0;
      if (k < TOTAL && (k == 50 || $urandom_range(0, 7) == 0)) start = 1'b1;
      if (k == TOTAL && start_at_done) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    ran   = 1'b1;
    check("done_pulses", 32'(dones), 32'd1);
    check("bank_toggles", 32'(toggles), 32'd12);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(ref_idle(ran), "idle_gap");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    compare(ref_idle(1'b0), "in_reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    compare(ref_idle(1'b0), "after_reset");

    run_transform(-1, 1'b0);
    idle_gap(int'($urandom_range(0, 4)));
    run_transform(-1, 1'b1);
    idle_gap(int'($urandom_range(1, 3)));
    // log_m=5, cnt=7
    run_transform(5 * STAGE + 7, 1'b0);
    idle_gap(int'($urandom_range(0, 3)));
    run_transform(-1, 1'b1);
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
